// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-lane round-robin arbiter.
package mux4_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Expand a 2-bit lane index into a 4-bit one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot2(input logic [SELW-1:0] sel);
    logic [NREQ-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

  // Lane index that follows p in round-robin order, wrapping 3 -> 0.
  function automatic logic [SELW-1:0] next_lane(input logic [SELW-1:0] p);
    return p + SELW'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting lane at or after start.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;

  // Scan from the farthest lane back to start so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start + SELW'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel between four lanes,
// with bursts capped at MAX_BURST transfers per grant.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW        = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [NREQ*DW-1:0]   in_data,
  output logic [NREQ-1:0]      in_ready,
  output logic [NREQ-1:0]      gnt,
  output logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  input  logic                 out_ready
);

  // Counter value at which the next transfer closes the burst.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t          state;
  state_t          next_state;
  logic [SELW-1:0] last;
  logic [3:0]      burst_cnt;

  logic [SELW-1:0] pick_start;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;

  logic            locked;
  logic            owner_valid;
  logic            xfer;
  logic            burst_done;
  logic            owner_release;
  logic            load_grant;
  logic            go_idle;

  // Owner status and the events that end or renew a grant.
  always_comb begin
    locked        = (state == LOCK);
    owner_valid   = in_valid[sel];
    xfer          = locked & owner_valid & out_ready;
    burst_done    = xfer & (burst_cnt == BURST_LAST);
    owner_release = locked & (~owner_valid | burst_done);
    // From IDLE rotation resumes after the last winner; on release the
    // current owner is pushed to the back of the queue.
    pick_start    = locked ? next_lane(sel) : next_lane(last);
    load_grant    = pick_found & (~locked | owner_release);
    go_idle       = owner_release & ~pick_found;
  end

  rr_pick4 u_pick (
    .req   (in_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: hold a lane while it keeps requesting, re-pick on release.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          next_state = LOCK;
        end
      end
      LOCK: begin
        if (owner_release && !pick_found) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant, select, pointer and burst counter; sel is kept when going idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      sel       <= '0;
      last      <= SELW'(NREQ - 1);
      burst_cnt <= '0;
    end else if (load_grant) begin
      gnt       <= onehot2(pick_idx);
      sel       <= pick_idx;
      last      <= pick_idx;
      burst_cnt <= '0;
    end else if (go_idle) begin
      gnt       <= '0;
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Outputs: lane mux on sel, ready only toward the granted lane.
  always_comb begin
    in_ready  = gnt & {NREQ{out_ready}};
    out_valid = locked & owner_valid;
    out_data  = in_data[int'(sel) * DW +: DW];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for reset,
// rotation, backpressure and abandon, then random traffic against a model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [3:0] in_ready_a, gnt_a;
  logic [1:0] sel_a, out_data_a;
  logic       out_valid_a;

  logic [3:0] in_ready_b, gnt_b;
  logic [1:0] sel_b, out_data_b;
  logic       out_valid_b;

  int checks;
  int errors;

  // Model state per instance: index 0 is MAX_BURST=4, index 1 is MAX_BURST=1.
  int m_owner[2];
  int m_last[2];
  int m_sel[2];
  int m_cnt[2];
  int m_max[2];

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic       ready;
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    logic       exp_ov;
    logic [1:0] exp_od;
    logic [3:0] exp_ir;
  } vec_t;

  vec_t vecs[11];

  mux4_rr_arbiter #(.DW(2), .MAX_BURST(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_a),
    .gnt       (gnt_a),
    .sel       (sel_a),
    .out_valid (out_valid_a),
    .out_data  (out_data_a),
    .out_ready (out_ready)
  );

  mux4_rr_arbiter #(.DW(2), .MAX_BURST(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_b),
    .gnt       (gnt_b),
    .sel       (sel_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_sel[i]   = 0;
      m_cnt[i]   = 0;
    end
  endtask

  // One clock of the reference: count transfers in the current grant and
  // hand the channel to the next requester after the owner.
  task automatic model_step();
    int w;
    bit x;
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        w = pick(in_valid, m_last[i] + 1);
        if (w >= 0) begin
          m_owner[i] = w; m_last[i] = w; m_sel[i] = w; m_cnt[i] = 0;
        end
      end else begin
        x = in_valid[m_owner[i]] && out_ready;
        if (x) m_cnt[i]++;
        if (!in_valid[m_owner[i]] || (x && m_cnt[i] == m_max[i])) begin
          w = pick(in_valid, m_owner[i] + 1);
          if (w >= 0) begin
            m_owner[i] = w; m_last[i] = w; m_sel[i] = w; m_cnt[i] = 0;
          end else begin
            m_owner[i] = -1; m_cnt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_models();
    logic [3:0] eg, eir;
    logic       eov;
    logic [1:0] eod;
    for (int i = 0; i < 2; i++) begin
      eg  = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
      eir = out_ready ? eg : 4'b0000;
      eov = (m_owner[i] >= 0) && in_valid[m_owner[i]];
      eod = in_data[m_sel[i] * 2 +: 2];
      if (i == 0) begin
        check_output("a_gnt", 32'(gnt_a), 32'(eg));
        check_output("a_sel", 32'(sel_a), 32'(m_sel[i]));
        check_output("a_out_valid", 32'(out_valid_a), 32'(eov));
        check_output("a_out_data", 32'(out_data_a), 32'(eod));
        check_output("a_in_ready", 32'(in_ready_a), 32'(eir));
      end else begin
        check_output("b_gnt", 32'(gnt_b), 32'(eg));
        check_output("b_sel", 32'(sel_b), 32'(m_sel[i]));
        check_output("b_out_valid", 32'(out_valid_b), 32'(eov));
        check_output("b_out_data", 32'(out_data_b), 32'(eod));
        check_output("b_in_ready", 32'(in_ready_b), 32'(eir));
      end
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Check current outputs against the model, then clock both DUT and model.
  task automatic advance();
    check_models();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(4'b0000, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_max[0] = 4;
    m_max[1] = 1;
    model_reset();

    vecs[0]  = '{4'b0100, 8'h20, 1'b1, 4'b0000, 2'd0, 1'b0, 2'b00, 4'b0000};
    vecs[1]  = '{4'b0100, 8'h20, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b10, 4'b0100};
    vecs[2]  = '{4'b0000, 8'h00, 1'b1, 4'b0100, 2'd2, 1'b0, 2'b00, 4'b0100};
    vecs[3]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 2'd2, 1'b0, 2'b00, 4'b0000};
    vecs[4]  = '{4'b1001, 8'hC1, 1'b0, 4'b0000, 2'd2, 1'b0, 2'b00, 4'b0000};
    vecs[5]  = '{4'b1001, 8'hC1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'b11, 4'b0000};
    vecs[6]  = '{4'b1001, 8'hC1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'b11, 4'b1000};
    vecs[7]  = '{4'b1001, 8'hC1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'b11, 4'b1000};
    vecs[8]  = '{4'b1001, 8'hC1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'b11, 4'b1000};
    vecs[9]  = '{4'b1001, 8'hC1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'b11, 4'b1000};
    vecs[10] = '{4'b1001, 8'hC1, 1'b1, 4'b0001, 2'd0, 1'b1, 2'b01, 4'b0001};

    @(negedge clk);
    do_reset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data, vecs[i].ready);
      check_output($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].exp_gnt));
      check_output($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(vecs[i].exp_sel));
      check_output($sformatf("vec%0d_out_valid", i), 32'(out_valid_a), 32'(vecs[i].exp_ov));
      check_output($sformatf("vec%0d_out_data", i), 32'(out_data_a), 32'(vecs[i].exp_od));
      check_output($sformatf("vec%0d_in_ready", i), 32'(in_ready_a), 32'(vecs[i].exp_ir));
      advance();
    end

    $display("[TB] rotation with all lanes valid");
    do_reset();
    apply_stimulus(4'b1111, 8'hE4, 1'b1);
    advance();
    check_output("first_gnt_after_reset", 32'(gnt_a), 32'h1);
    check_output("rr_gnt_0", 32'(gnt_b), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      advance();
      check_output($sformatf("rr_sel_%0d", k), 32'(sel_b), 32'(k % 4));
      check_output($sformatf("rr_valid_%0d", k), 32'(out_valid_b), 32'h1);
    end

    $display("[TB] asynchronous reset mid-burst");
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_gnt", 32'(gnt_a), 32'h0);
    check_output("async_rst_sel", 32'(sel_b), 32'h0);
    check_output("async_rst_out_valid", 32'(out_valid_a), 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    $display("[TB] backpressure and abandon");
    apply_stimulus(4'b0010, 8'h04, 1'b0);
    advance();
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("bp_sel_%0d", k), 32'(sel_a), 32'h1);
      check_output($sformatf("bp_in_ready_%0d", k), 32'(in_ready_a), 32'h0);
      advance();
    end
    apply_stimulus(4'b0010, 8'h04, 1'b1);
    advance();
    apply_stimulus(4'b0100, 8'h24, 1'b1);
    advance();
    check_output("abandon_gnt", 32'(gnt_a), 32'h4);
    apply_stimulus(4'b0000, 8'h00, 1'b1);
    advance();
    advance();
    check_output("abandon_idle_gnt", 32'(gnt_a), 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [3:0] v;
      v = in_valid;
      if ($urandom_range(0, 2) == 0) v = 4'($urandom_range(0, 15));
      apply_stimulus(v, 8'($urandom), ($urandom_range(0, 3) != 0));
      advance();
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        check_output("rand_rst_gnt", 32'(gnt_a | gnt_b), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 select datapath. It shares one output channel between four valid/ready requesters and drives the 2-bit select, with s1 = sel[1] and s0 = sel[0]. Grants are registered and held for bursts of up to MAX_BURST transfers, so lanes rotate fairly. It sits in front of the 2-bit 4:1 mux tree and can also steer an external instance through `sel`.

## Interface
- DW, 2: data width per lane.
- MAX_BURST, 4: maximum transfers per grant before forced rotation; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  4  per-requester valid.
- in_data  in  4*DW  packed lane data; lane i is bits [i*DW +: DW].
- in_ready  out  4  per-requester accept; equals gnt[i] & out_ready.
- gnt  out  4  registered one-hot grant; all zero when idle.
- sel  out  2  registered select of the owning lane; bit 1 drives s1, bit 0 drives s0.
- out_valid  out  1  gnt-qualified valid of the owner.
- out_data  out  DW  in_data lane `sel`.
- out_ready  in  1  downstream accept.

## Operation
- **Reset values.** State IDLE, gnt=0, sel=0, burst_cnt=0, last=3 (lane 0 has first priority), out_valid=0.
- **States.** Two states: IDLE and LOCK.
- **IDLE.** If |in_valid, the arbiter picks a winner in round-robin order starting at last+1 mod 4. At the edge it loads gnt=onehot(winner), sel=winner, last=winner, burst_cnt=0, and moves to LOCK. With no valid inputs it stays in IDLE.
- **LOCK outputs.**
  - out_valid = in_valid[sel]
  - out_data = in_data[sel]
  - in_ready[sel] = out_ready; all other in_ready bits are 0.
- **Transfer.** xfer = in_valid[sel] & out_ready. On each xfer, burst_cnt increments.
- **Release condition.** Release when either:
  - xfer & (burst_cnt == MAX_BURST-1), or
  - in_valid[sel] == 0 (owner idle or abandoned).
- **On release.** The arbiter re-picks from the current in_valid, starting at sel+1 mod 4; the current owner ranks last.
  - If a winner exists, it reloads gnt, sel, last and burst_cnt=0 and stays in LOCK. Back-to-back transfers have zero bubble.
  - If no winner exists, it goes to IDLE with gnt=0 and sel holding its value.
- **Re-pick of the owner.** If the owner is the sole requester at release it is re-granted. If its valid then drops, the next cycle releases, costing one bubble; this is legal.
- **Requester protocol.** A requester holds in_valid and in_data stable until in_ready. Dropping valid early abandons the request without error.
- **Arithmetic.** burst_cnt is 4 bits and is never compared beyond MAX_BURST-1. The pointer is 2 bits and wraps 3→0.

## Timing
- Request to grant is one cycle. in_valid rising in cycle N gives gnt/sel/out_valid in cycle N+1.
- Data path is combinational from in_data through `sel`; there is no data latency.
- in_ready is a combinational function of the registered gnt and out_ready; there is no path from in_valid to in_ready.
- sel changes only at an edge where state or owner changes, never mid-transfer.
- An async reset asserted mid-burst forces the reset values immediately. The in-flight transfer is dropped, and the requester re-presents it after reset.
- If the release condition and a new request arrive in the same cycle, the new request is eligible in that cycle's re-pick.

## Structure
- **Shared package mux4_arb_pkg.** Contains:
  - the state enum {IDLE, LOCK}
  - localparam NREQ=4
  - localparam SELW=2
  - a function onehot2(sel) returning 4 bits.
- **Sub-module rr_pick4.** Combinational round-robin picker.
  - Inputs: req[3:0], start[1:0].
  - Outputs: found, idx[1:0].
  - Used for both the IDLE pick and the LOCK re-pick.
- **Top level.** Holds the FSM, burst counter, pointer and the lane select for out_data.

## Test plan
- **Reset.** rst_n=0 mid-stream → gnt=0, sel=0, out_valid=0 at once. After release, in_valid=4'b1111 → gnt=0001 one cycle later.
- **Single lane.** in_valid=0100, in_data lane2=2'b10, out_ready=1 → cycle+1: sel=2, out_data=10, in_ready=0100.
- **Round robin.** MAX_BURST=1, all four valid continuously, out_ready=1 → grant order 0,1,2,3,0 on consecutive cycles with no bubble.
- **Burst cap.** MAX_BURST=4, lanes 0 and 3 valid → 4 transfers on lane 0, then sel=3 for 4 transfers, then back to 0.
- **Backpressure.** Owner lane1, out_ready=0 for 5 cycles → sel stays 1, burst_cnt is unchanged, in_ready=0000.
- **Abandon.** Owner lane1 drops in_valid while lane 2 is valid → next cycle gnt=0100. If no lane is valid → IDLE, gnt=0000.
